uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Consumes the byte stream produced by the UART receiver (already synchronized into this clock domain) and turns it into register-file transactions. It parses two frame types (write: opcode, address, data; read: opcode, address), issues single-cycle register-file strobes, and returns read data as one byte toward the transmit-side FIFO. It sits between the RX data synchronizer and the register file / TX FIFO in the system controller.

## Interface
- DATA_WIDTH, 8, width of UART bytes, register-file data and return byte
- ADDR_WIDTH, 4, register-file address width; taken from the LSBs of the address byte
- TIMEOUT_CYCLES, 1023, idle cycles allowed between bytes of one frame (used only with the timeout feature)
- CLK  input  1  single clock for all logic
- RST  input  1  asynchronous, active-low reset
- RX_P_DATA  input  DATA_WIDTH  received byte
- RX_D_VLD  input  1  one-cycle pulse per received byte
- RF_ADDR  output  ADDR_WIDTH  register-file address
- RF_WR_EN  output  1  one-cycle write strobe
- RF_WR_DATA  output  DATA_WIDTH  write data
- RF_RD_EN  output  1  one-cycle read strobe
- RF_RD_DATA  input  DATA_WIDTH  read data, valid with RF_RD_VLD
- RF_RD_VLD  input  1  read-data valid pulse
- FIFO_FULL  input  1  TX FIFO cannot accept a byte
- TX_P_DATA  output  DATA_WIDTH  byte to TX FIFO
- TX_D_VLD  output  1  write strobe to TX FIFO
- CMD_ERR  output  1  one-cycle pulse on a discarded byte or aborted frame

## Operation
- Opcodes: WR_CMD = 0xAA, RD_CMD = 0xBB. Every other byte received in IDLE is discarded, with a CMD_ERR pulse.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND.
- IDLE: 0xAA moves to WR_ADDR; 0xBB moves to RD_ADDR.
- WR_ADDR: on a byte, latch RX_P_DATA[ADDR_WIDTH-1:0] into RF_ADDR and move to WR_DATA.
- WR_DATA: on a byte, latch RF_WR_DATA and pulse RF_WR_EN for exactly one cycle, then return to IDLE.
- RD_ADDR: on a byte, latch RF_ADDR, pulse RF_RD_EN for one cycle and move to RD_WAIT.
- RD_WAIT: on RF_RD_VLD, latch RF_RD_DATA into TX_P_DATA and move to RD_SEND.
- RD_SEND: when FIFO_FULL = 0, pulse TX_D_VLD for one cycle and return to IDLE. While FIFO_FULL = 1, hold the state and TX_P_DATA.
- Bytes arriving in RD_WAIT or RD_SEND are dropped, each with a CMD_ERR pulse. The state does not change.
- RF_ADDR, RF_WR_DATA and TX_P_DATA hold their last value between transactions.

## Timing
- Reset values: every output is 0; state is IDLE.
- Reset asserted mid-frame aborts the frame with no strobes. The first byte after reset release is treated as an opcode.
- Write latency: RF_WR_EN is high in the cycle after the RX_D_VLD of the data byte.
- Read latency: RF_RD_EN is high in the cycle after the RX_D_VLD of the address byte.
- TX_D_VLD is high no earlier than the cycle after RF_RD_VLD, and only in a cycle where FIFO_FULL = 0 as sampled in the preceding cycle.
- RX_D_VLD and RF_RD_VLD in the same cycle in RD_WAIT: the read data is captured and the byte is dropped with CMD_ERR.
- Back-to-back bytes, one per cycle, are accepted in IDLE, WR_ADDR, WR_DATA and RD_ADDR.

## Configuration
- CMD_TIMEOUT_EN defined:
  - An idle counter runs in WR_ADDR, WR_DATA and RD_ADDR and clears on every RX_D_VLD.
  - When it reaches TIMEOUT_CYCLES, the state returns to IDLE and CMD_ERR pulses once.
  - RD_WAIT and RD_SEND never time out.
- CMD_TIMEOUT_EN undefined: no counter is built, and a partial frame waits indefinitely.

## Structure
- Package uart_cmd_pkg holds:
  - the state enum;
  - WR_CMD and RD_CMD localparams;
  - the default DATA_WIDTH and ADDR_WIDTH.
- One sub-module, cmd_timeout_cnt (counter with clear, enable and terminal-count pulse). It is instantiated only under CMD_TIMEOUT_EN.

## Test plan
- Write frame: 0xAA, 0x05, 0x3C → one RF_WR_EN pulse with RF_ADDR = 5 and RF_WR_DATA = 0x3C; no CMD_ERR.
- Read frame with FIFO_FULL = 0: 0xBB, 0x02, then RF_RD_DATA = 0x7E returned 1 cycle after RF_RD_EN → one TX_D_VLD pulse with TX_P_DATA = 0x7E.
- Read with FIFO_FULL held high for 10 cycles → TX_D_VLD stays low and TX_P_DATA is held; one pulse follows the release.
- Unknown byte 0x11 in IDLE, and a byte arriving during RD_WAIT → one CMD_ERR pulse each; no RF strobes; the following 0xAA frame completes normally.
- Reset asserted after 0xAA, 0x05 → no RF_WR_EN, all outputs 0; the next frame 0xAA, 0x01, 0x55 writes address 1.
- With CMD_TIMEOUT_EN defined: send 0xAA, then idle for TIMEOUT_CYCLES → one CMD_ERR pulse, state returns to IDLE, and the next byte 0x05 is treated as an opcode (CMD_ERR).

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder.
// Holds the FSM state enum, the opcodes and the default widths.
package uart_cmd_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_SEND
  } state_t;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Idle counter with clear and enable; tc pulses in the LIMIT-th
// consecutive enabled cycle without a clear.
module cmd_timeout_cnt #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  assign tc = en && !clr && (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tc) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses UART write/read frames into register-file strobes and TX bytes.
// Define CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  RF_RD_EN,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VLD,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] WR_OP = DATA_WIDTH'(WR_CMD);
  localparam logic [DATA_WIDTH-1:0] RD_OP = DATA_WIDTH'(RD_CMD);

  state_t state_q, state_d;

  logic wr_en_d, rd_en_d, tx_vld_d, err_d;
  logic ld_addr, ld_wdata, ld_rdata;
  logic timeout_hit;

  logic unused_rx_hi;
  assign unused_rx_hi = ^RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];

`ifdef CMD_TIMEOUT_EN
  logic to_run;

  assign to_run = (state_q == WR_ADDR) ||
                  (state_q == WR_DATA) ||
                  (state_q == RD_ADDR);

  cmd_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (RX_D_VLD || !to_run),
    .en    (to_run),
    .tc    (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    tx_vld_d = 1'b0;
    err_d    = 1'b0;
    ld_addr  = 1'b0;
    ld_wdata = 1'b0;
    ld_rdata = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_OP) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == RD_OP) begin
            state_d = RD_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          ld_addr = 1'b1;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          ld_wdata = 1'b1;
          wr_en_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          ld_addr = 1'b1;
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (RF_RD_VLD) begin
          ld_rdata = 1'b1;
          state_d  = RD_SEND;
        end
        err_d = RX_D_VLD;
      end
      RD_SEND: begin
        if (!FIFO_FULL) begin
          tx_vld_d = 1'b1;
          state_d  = IDLE;
        end
        err_d = RX_D_VLD;
      end
      default: state_d = IDLE;
    endcase
    // Only fires in states where no byte arrived this cycle.
    if (timeout_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;
    end else begin
      RF_WR_EN <= wr_en_d;
      RF_RD_EN <= rd_en_d;
      TX_D_VLD <= tx_vld_d;
      CMD_ERR  <= err_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      TX_P_DATA  <= '0;
    end else begin
      if (ld_addr) begin
        RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
      end
      if (ld_wdata) begin
        RF_WR_DATA <= RX_P_DATA;
      end
      if (ld_rdata) begin
        TX_P_DATA <= RF_RD_DATA;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_cmd_decoder;

  localparam int TO = 1023;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_vld = 1'b0;
  logic [3:0] rf_addr;
  logic       rf_wr_en;
  logic [7:0] rf_wr_data;
  logic       rf_rd_en;
  logic [7:0] rf_rd_data = '0;
  logic       rf_rd_vld = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_P_DATA  (rx_data),
    .RX_D_VLD   (rx_vld),
    .RF_ADDR    (rf_addr),
    .RF_WR_EN   (rf_wr_en),
    .RF_WR_DATA (rf_wr_data),
    .RF_RD_EN   (rf_rd_en),
    .RF_RD_DATA (rf_rd_data),
    .RF_RD_VLD  (rf_rd_vld),
    .FIFO_FULL  (fifo_full),
    .TX_P_DATA  (tx_data),
    .TX_D_VLD   (tx_vld),
    .CMD_ERR    (cmd_err)
  );

  always @(negedge clk) begin
    if (rf_wr_en) n_wr++;
    if (rf_rd_en) n_rd++;
    if (tx_vld) n_tx++;
    if (cmd_err) n_err++;
  end

  // Called on a falling edge; returns on the next one, so calls chain back to back.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
         tx_data, tx_vld, cmd_err} !== '0) begin
      errors++;
      $display("FAIL %s: outputs addr=%0h wr=%0b wd=%0h rd=%0b tx=%0h tv=%0b err=%0b, required all 0",
               name, rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_data, tx_vld, cmd_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    idle(2);
    chk_zero("after_release");
  endtask

  task automatic test_write;
    int w0, r0, e0;
    w0 = n_wr; r0 = n_rd; e0 = n_err;
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    checks++;
    if (rf_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL wr_latency: RF_WR_EN=%0b required 1", rf_wr_en);
    end
    checks++;
    if (rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
      errors++;
      $display("FAIL wr_payload: addr=%0h data=%0h required 5/3c", rf_addr, rf_wr_data);
    end
    idle(3);
    checks++;
    if (n_wr - w0 != 1 || n_rd != r0 || n_err != e0) begin
      errors++;
      $display("FAIL wr_counts: wr=%0d rd=%0d err=%0d required 1/0/0",
               n_wr - w0, n_rd - r0, n_err - e0);
    end
  endtask

  task automatic test_read;
    int t0;
    t0 = n_tx;
    send(8'hBB);
    send(8'h02);
    checks++;
    if (rf_rd_en !== 1'b1 || rf_addr !== 4'h2) begin
      errors++;
      $display("FAIL rd_latency: RF_RD_EN=%0b addr=%0h required 1/2", rf_rd_en, rf_addr);
    end
    idle(1);
    rf_rd_data = 8'h7E;
    rf_rd_vld  = 1'b1;
    idle(1);
    rf_rd_vld  = 1'b0;
    rf_rd_data = 8'h00;
    checks++;
    if (tx_vld !== 1'b0 || tx_data !== 8'h7E) begin
      errors++;
      $display("FAIL rd_capture: TX_D_VLD=%0b TX_P_DATA=%0h required 0/7e", tx_vld, tx_data);
    end
    idle(1);
    checks++;
    if (tx_vld !== 1'b1 || tx_data !== 8'h7E) begin
      errors++;
      $display("FAIL rd_send: TX_D_VLD=%0b TX_P_DATA=%0h required 1/7e", tx_vld, tx_data);
    end
    idle(3);
    checks++;
    if (n_tx - t0 != 1) begin
      errors++;
      $display("FAIL rd_tx_count: got %0d required 1", n_tx - t0);
    end
  endtask

  task automatic test_fifo_full;
    int t0;
    int bad;
    t0 = n_tx;
    bad = 0;
    fifo_full = 1'b1;
    send(8'hBB);
    send(8'h03);
    rf_rd_data = 8'hC3;
    rf_rd_vld  = 1'b1;
    idle(1);
    rf_rd_vld  = 1'b0;
    rf_rd_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (tx_vld !== 1'b0 || tx_data !== 8'hC3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_hold: %0d bad cycles, TX_D_VLD=%0b TX_P_DATA=%0h required 0/c3",
               bad, tx_vld, tx_data);
    end
    fifo_full = 1'b0;
    idle(1);
    checks++;
    if (tx_vld !== 1'b1 || tx_data !== 8'hC3) begin
      errors++;
      $display("FAIL full_release: TX_D_VLD=%0b TX_P_DATA=%0h required 1/c3", tx_vld, tx_data);
    end
    idle(3);
    checks++;
    if (n_tx - t0 != 1) begin
      errors++;
      $display("FAIL full_tx_count: got %0d required 1", n_tx - t0);
    end
  endtask

  task automatic test_errors;
    int w0, r0, e0;
    w0 = n_wr; r0 = n_rd; e0 = n_err;
    send(8'h11);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL err_unknown: CMD_ERR=%0b required 1", cmd_err);
    end
    idle(2);
    send(8'hBB);
    send(8'h04);
    send(8'h99);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL err_rd_wait: CMD_ERR=%0b required 1", cmd_err);
    end
    rf_rd_data = 8'h5A;
    rf_rd_vld  = 1'b1;
    send(8'h77);
    rf_rd_vld  = 1'b0;
    rf_rd_data = 8'h00;
    checks++;
    if (cmd_err !== 1'b1 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL err_same_cycle: CMD_ERR=%0b TX_P_DATA=%0h required 1/5a", cmd_err, tx_data);
    end
    idle(3);
    send(8'hAA);
    send(8'h06);
    send(8'h81);
    checks++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'h6 || rf_wr_data !== 8'h81) begin
      errors++;
      $display("FAIL err_recover: wr=%0b addr=%0h data=%0h required 1/6/81",
               rf_wr_en, rf_addr, rf_wr_data);
    end
    idle(2);
    checks++;
    if (n_err - e0 != 3 || n_wr - w0 != 1 || n_rd - r0 != 1) begin
      errors++;
      $display("FAIL err_counts: err=%0d wr=%0d rd=%0d required 3/1/1",
               n_err - e0, n_wr - w0, n_rd - r0);
    end
  endtask

  task automatic test_reset_midframe;
    int w0;
    w0 = n_wr;
    send(8'hAA);
    send(8'h05);
    rst_n = 1'b0;
    idle(1);
    chk_zero("midframe_reset");
    rst_n = 1'b1;
    idle(1);
    send(8'hAA);
    send(8'h01);
    send(8'h55);
    checks++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'h1 || rf_wr_data !== 8'h55) begin
      errors++;
      $display("FAIL midframe_next: wr=%0b addr=%0h data=%0h required 1/1/55",
               rf_wr_en, rf_addr, rf_wr_data);
    end
    idle(2);
    checks++;
    if (n_wr - w0 != 1) begin
      errors++;
      $display("FAIL midframe_wr_count: got %0d required 1", n_wr - w0);
    end
  endtask

  task automatic test_back_to_back;
    int e0;
    e0 = n_err;
    send(8'hAA);
    send(8'h1F);
    send(8'hE1);
    checks++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'hF || rf_wr_data !== 8'hE1) begin
      errors++;
      $display("FAIL b2b_write: wr=%0b addr=%0h data=%0h required 1/f/e1",
               rf_wr_en, rf_addr, rf_wr_data);
    end
    send(8'hBB);
    send(8'h07);
    checks++;
    if (rf_rd_en !== 1'b1 || rf_addr !== 4'h7) begin
      errors++;
      $display("FAIL b2b_read: rd=%0b addr=%0h required 1/7", rf_rd_en, rf_addr);
    end
    rf_rd_data = 8'h24;
    rf_rd_vld  = 1'b1;
    idle(1);
    rf_rd_vld  = 1'b0;
    idle(3);
    checks++;
    if (tx_data !== 8'h24 || n_err != e0) begin
      errors++;
      $display("FAIL b2b_tail: TX_P_DATA=%0h err=%0d required 24/0", tx_data, n_err - e0);
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    n = 0;
    send(8'hAA);
    while (cmd_err !== 1'b1 && n < 2 * TO) begin
      idle(1);
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_cycles: CMD_ERR after %0d cycles required %0d", n, TO);
    end
    idle(1);
    send(8'h05);
    checks++;
    if (cmd_err !== 1'b1 || rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: CMD_ERR=%0b RF_WR_EN=%0b required 1/0", cmd_err, rf_wr_en);
    end
    idle(2);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_write;
    test_read;
    test_fifo_full;
    test_errors;
    test_reset_midframe;
    test_back_to_back;
`ifdef CMD_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
